fault_supervisor: RTL
=====================

// Module: fault_supervisor
// PURPOSE
//  Protection sequencer for one monitored power channel. Consumes the qualified
//  flags of one debounce/persistence filter (flt_hi, flt_pers, flt_lo). Drives:
//  - the channel enable, with soft-start, warn, trip, hold-off and retry;
//  - a lockout after RETRY_MAX consecutive failed retries, cleared by software.
//  Sits between the fault filter and the power-stage enable / status registers.
// PARAMETERS
//  SS_CYCLES    16'd2000   cycles in SOFTSTART (flt_hi ignored there), min 1
//  HOLD_CYCLES  16'd20000  consecutive flt_lo cycles in HOLDOFF before retry, min 1
//  HEAL_CYCLES  16'd50000  consecutive RUN cycles that clear retry_cnt, min 1
//  RETRY_MAX    4'd3       trips allowed before LOCKOUT (0 = lock on first trip)
// PORTS
//  clk        in   1  clock
//  rst        in   1  synchronous reset, active high
//  en         in   1  channel enable request (level)
//  clr        in   1  software clear pulse (leave LOCKOUT, zero fault_cnt)
//  flt_hi     in   1  debounced fault high
//  flt_pers   in   1  persistent fault high
//  flt_lo     in   1  debounced fault low (fault gone)
//  pwr_en     out  1  power stage enable
//  warn       out  1  high in WARN
//  trip_evt   out  1  one-cycle pulse in TRIP
//  lockout    out  1  high in LOCKOUT
//  retry_cnt  out  4  trips since last heal/IDLE
//  fault_cnt  out  8  total trips, saturates at 8'hFF
//  state      out  3  IDLE=0 SOFTSTART=1 RUN=2 WARN=3 TRIP=4 HOLDOFF=5 LOCKOUT=6
// BEHAVIOUR
//  Moore FSM:
//  - All outputs are registered or decoded from the registered state; no
//    combinational input->output path.
//  - A flag sampled at edge N changes the state after edge N.
//  - pwr_en follows the state in that same cycle.
//  rst: state=IDLE, timer=0, retry_cnt=0, fault_cnt=0, all 1-bit outputs 0.
//  pwr_en=1 only in SOFTSTART, RUN, WARN.
//  Transition priority, highest first:
//  - en=0 (all states except LOCKOUT) -> IDLE;
//  - flt_pers -> TRIP;
//  - state-specific rules below.
//  IDLE: retry_cnt<=0, timer<=0. en=1 -> SOFTSTART.
//  SOFTSTART: timer counts from 0; at timer==SS_CYCLES-1 -> RUN, timer<=0.
//  RUN:
//  - flt_hi -> WARN, timer<=0.
//  - Otherwise timer counts; at timer==HEAL_CYCLES-1, retry_cnt<=0.
//  - timer saturates there.
//  WARN: flt_lo -> RUN, timer<=0. Otherwise stay; timer held at 0.
//  TRIP: exactly 1 cycle; trip_evt=1, fault_cnt+1 (saturating).
//  - retry_cnt==RETRY_MAX -> LOCKOUT.
//  - Else retry_cnt+1 -> HOLDOFF, timer<=0.
//  HOLDOFF:
//  - timer counts only while flt_lo=1; flt_lo=0 resets timer to 0.
//  - flt_lo=1 at timer==HOLD_CYCLES-1 -> SOFTSTART, timer<=0.
//  LOCKOUT:
//  - Ignores en and all flags.
//  - clr=1 with flt_lo=1 -> IDLE; clr with flt_lo=0 is ignored.
//  clr: fault_cnt<=0 in any state, same cycle. If TRIP increments in that cycle,
//  clr wins: fault_cnt=0.
//  timer: 16-bit, never wraps.
//  retry_cnt: never exceeds RETRY_MAX.
//  Simultaneous flt_hi and flt_pers: TRIP. Simultaneous flt_hi and flt_lo in WARN:
//  RUN (filter guarantees exclusive; defined anyway).
//  rst mid-operation: IDLE next cycle; pwr_en=0 in the cycle after the rst edge.
// TESTING (bench params SS=4 HOLD=8 HEAL=16 RETRY_MAX=2)
//  1. rst, en=1, flags 0 -> state 1 for 4 cycles, then 2. pwr_en=1 from cycle 1.
//  2. RUN, flt_hi=1 3 cyc, then flt_lo=1 -> WARN (warn=1) then RUN. No trip_evt.
//  3. RUN, flt_pers 1 cyc:
//     - -> TRIP, trip_evt pulse, pwr_en=0, retry_cnt=1.
//     - flt_lo held 8 cyc -> SOFTSTART.
//  4. Trip 3 times without heal:
//     - third trip -> LOCKOUT, lockout=1, fault_cnt=3.
//     - en toggles have no effect.
//     - clr with flt_lo=1 -> IDLE, fault_cnt=0.
//  5. HOLDOFF, flt_lo drops at timer=5 -> timer 0. Retry needs 8 fresh flt_lo cyc.
//  6. Trip once, RUN 16 cyc -> retry_cnt=0. Also rst asserted in WARN -> IDLE next
//     cycle, all outputs 0.

Source files
------------

// File: rtl/fault_supervisor.sv
// fault_supervisor: protection sequencer for one power channel (soft-start, warn, trip, hold-off, retry, lockout)
module fault_supervisor #(
    parameter logic [15:0] SS_CYCLES   = 16'd2000,
    parameter logic [15:0] HOLD_CYCLES = 16'd20000,
    parameter logic [15:0] HEAL_CYCLES = 16'd50000,
    parameter logic [3:0]  RETRY_MAX   = 4'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       flt_hi,
    input  logic       flt_pers,
    input  logic       flt_lo,
    output logic       pwr_en,
    output logic       warn,
    output logic       trip_evt,
    output logic       lockout,
    output logic [3:0] retry_cnt,
    output logic [7:0] fault_cnt,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SOFTSTART = 3'd1,
        RUN       = 3'd2,
        WARN      = 3'd3,
        TRIP      = 3'd4,
        HOLDOFF   = 3'd5,
        LOCKOUT   = 3'd6
    } state_t;
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  fault_q, fault_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= 16'd0;
            retry_q <= 4'd0;
            fault_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            fault_q <= fault_d;
        end
    end
    // TRIP is always a single cycle, so flt_pers is not re-evaluated there
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        fault_d = clr ? 8'd0 : (state_q == TRIP && fault_q != 8'hFF) ? fault_q + 8'd1 : fault_q;
        if (state_q == LOCKOUT) begin
            if (clr && flt_lo) state_d = IDLE;
        end else if (!en) begin
            state_d = IDLE;
        end else if (state_q == TRIP) begin
            if (retry_q == RETRY_MAX) state_d = LOCKOUT;
            else begin
                state_d = HOLDOFF;
                retry_d = retry_q + 4'd1;
            end
        end else if (flt_pers) begin
            state_d = TRIP;
        end else begin
            case (state_q)
                IDLE:      state_d = SOFTSTART;
                SOFTSTART: if (timer_q == SS_CYCLES - 16'd1) state_d = RUN;
                           else timer_d = timer_q + 16'd1;
                RUN:       if (flt_hi) state_d = WARN;
                           else if (timer_q == HEAL_CYCLES - 16'd1) retry_d = 4'd0;
                           else timer_d = timer_q + 16'd1;
                WARN:      if (flt_lo) state_d = RUN;
                HOLDOFF:   if (flt_lo && timer_q == HOLD_CYCLES - 16'd1) state_d = SOFTSTART;
                           else timer_d = flt_lo ? timer_q + 16'd1 : 16'd0;
                default:   state_d = IDLE;
            endcase
        end
        if (state_d != state_q) timer_d = 16'd0;
        if (state_d == IDLE) retry_d = 4'd0;
    end
    assign pwr_en    = state_q == SOFTSTART || state_q == RUN || state_q == WARN;
    assign warn      = state_q == WARN;
    assign trip_evt  = state_q == TRIP;
    assign lockout   = state_q == LOCKOUT;
    assign retry_cnt = retry_q;
    assign fault_cnt = fault_q;
    assign state     = state_q;
endmodule
